// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port, byte-wide,
// write-first synchronous RAM. A per-requester lock keeps multi-byte sequences
// atomic. A lock-length limit bounds how long one requester can hold the RAM.
module mem_arbiter #(
  parameter int unsigned addr_width = 9,
  parameter int unsigned lock_max   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [addr_width-1:0] addr0,
  input  logic [addr_width-1:0] addr1,
  input  logic [7:0]            wdata0,
  input  logic [7:0]            wdata1,
  input  logic                  lock0,
  input  logic                  lock1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [7:0]            rdata,
  output logic [addr_width-1:0] ram_addr,
  output logic [7:0]            ram_wdata,
  output logic                  ram_we,
  input  logic [7:0]            ram_rdata
);

  localparam logic [1:0] StOpen  = 2'd0;
  localparam logic [1:0] StLock0 = 2'd1;
  localparam logic [1:0] StLock1 = 2'd2;

  localparam logic [7:0] LockMax = 8'(lock_max);

  logic [1:0]            state_q, state_d;
  logic                  last_q, last_d;        // last winner, round-robin pointer
  logic [7:0]            cnt_q, cnt_d;          // cycles the current lock has been held
  logic                  prio_q, prio_d;        // one-shot priority after a lock timeout
  logic                  prio_id_q, prio_id_d;  // requester that owns that priority
  logic [addr_width-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]            ram_wdata_q, ram_wdata_d;
  logic                  ram_we_q, ram_we_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_id_q, s1_id_d;
  logic                  s2_valid_q, s2_valid_d;
  logic                  s2_id_q, s2_id_d;

  logic                  pick1;

  // Combinational grant: only the lock owner may be granted while locked.
  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    pick1 = 1'b0;
    if (!reset) begin
      case (state_q)
        StOpen: begin
          if (req0 && req1) begin
            // A timed-out lock hands the next tie to the other requester.
            pick1 = prio_q ? prio_id_q : ~last_q;
            gnt1  = pick1;
            gnt0  = ~pick1;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
        StLock0: gnt0 = req0;
        StLock1: gnt1 = req1;
        default: begin
          gnt0 = 1'b0;
          gnt1 = 1'b0;
        end
      endcase
    end
  end

  // Next-state for the lock FSM, round-robin pointer and lock counter.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    prio_d    = 1'b0;
    prio_id_d = prio_id_q;
    case (state_q)
      StOpen: begin
        if (gnt0) begin
          last_d = 1'b0;
          if (lock0) begin
            state_d = StLock0;
            cnt_d   = 8'd1;
          end
        end else if (gnt1) begin
          last_d = 1'b1;
          if (lock1) begin
            state_d = StLock1;
            cnt_d   = 8'd1;
          end
        end
      end
      StLock0: begin
        cnt_d = cnt_q + 8'd1;
        if (!lock0) begin
          state_d = StOpen;
        end else if (cnt_d == LockMax) begin
          state_d   = StOpen;
          prio_d    = 1'b1;
          prio_id_d = 1'b1;
        end
      end
      StLock1: begin
        cnt_d = cnt_q + 8'd1;
        if (!lock1) begin
          state_d = StOpen;
        end else if (cnt_d == LockMax) begin
          state_d   = StOpen;
          prio_d    = 1'b1;
          prio_id_d = 1'b0;
        end
      end
      default: state_d = StOpen;
    endcase
  end

  // RAM port capture and read-return pipeline next-state.
  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    if (gnt0) begin
      ram_addr_d  = addr0;
      ram_wdata_d = wdata0;
      ram_we_d    = req0 & we0;
    end else if (gnt1) begin
      ram_addr_d  = addr1;
      ram_wdata_d = wdata1;
      ram_we_d    = req1 & we1;
    end
    s1_valid_d = (gnt0 & ~we0) | (gnt1 & ~we1);
    s1_id_d    = gnt1;
    s2_valid_d = s1_valid_q;
    s2_id_d    = s1_id_q;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StOpen;
      last_q      <= 1'b1;
      cnt_q       <= 8'd0;
      prio_q      <= 1'b0;
      prio_id_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 8'd0;
      ram_we_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_id_q     <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_id_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      prio_q      <= prio_d;
      prio_id_q   <= prio_id_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      s2_valid_q  <= s2_valid_d;
      s2_id_q     <= s2_id_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign rvalid0   = s2_valid_q & ~s2_id_q;
  assign rvalid1   = s2_valid_q & s2_id_q;
  assign rdata     = ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a write-first byte RAM model.
module tb_mem_arbiter;

  logic       clk;
  logic       reset;
  logic       req0, req1, we0, we1, lock0, lock1;
  logic [8:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata;
  logic [8:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic [7:0] ram_rdata;

  logic [7:0] mem [512];
  logic       pl_en;
  logic [8:0] pl_addr;
  logic [7:0] pl_data;

  int n_checks;
  int n_fail;

  mem_arbiter #(
    .addr_width(9),
    .lock_max  (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .req1     (req1),
    .we0      (we0),
    .we1      (we1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .lock0    (lock0),
    .lock1    (lock1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .rdata    (rdata),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_we   (ram_we),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-first synchronous RAM, with a bench-side preload port.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= ram_we ? ram_wdata : mem[ram_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    lock0 = 1'b0; lock1 = 1'b0;
    addr0 = 9'h000; addr1 = 9'h000; wdata0 = 8'h00; wdata1 = 8'h00;
  endtask

  task automatic load_ram(input logic [8:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    n_checks++;
    if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt0: got %b expected 0", gnt0); end
    n_checks++;
    if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt1: got %b expected 0", gnt1); end
    step();
    idle_inputs();
    load_ram(9'h010, 8'hA5);
    load_ram(9'h011, 8'h11);
    load_ram(9'h012, 8'h22);
    load_ram(9'h005, 8'h55);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got %b expected 0", ram_we); end
    n_checks++;
    if (ram_addr !== 9'h000) begin
      n_fail++; $display("FAIL reset_ram_addr: got %h expected 000", ram_addr);
    end
    n_checks++;
    if (ram_wdata !== 8'h00) begin
      n_fail++; $display("FAIL reset_ram_wdata: got %h expected 00", ram_wdata);
    end
    n_checks++;
    if ({rvalid0, rvalid1} !== 2'b00) begin
      n_fail++; $display("FAIL reset_rvalid: got %b expected 00", {rvalid0, rvalid1});
    end
    step();
  endtask

  task automatic test_single_read();
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'h010;
    @(negedge clk);
    n_checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_fail++; $display("FAIL read_gnt: got %b expected 10", {gnt0, gnt1});
    end
    step();
    req0 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ram_addr !== 9'h010) begin
      n_fail++; $display("FAIL read_ram_addr: got %h expected 010", ram_addr);
    end
    n_checks++;
    if (ram_we !== 1'b0) begin n_fail++; $display("FAIL read_ram_we: got %b expected 0", ram_we); end
    step();
    @(negedge clk);
    n_checks++;
    if ({rvalid0, rvalid1} !== 2'b10) begin
      n_fail++; $display("FAIL read_rvalid: got %b expected 10", {rvalid0, rvalid1});
    end
    n_checks++;
    if (rdata !== 8'hA5) begin n_fail++; $display("FAIL read_rdata: got %h expected a5", rdata); end
    step();
    @(negedge clk);
    n_checks++;
    if (rvalid0 !== 1'b0) begin
      n_fail++; $display("FAIL read_rvalid_once: got %b expected 0", rvalid0);
    end
    step();
  endtask

  task automatic test_tie_rr();
    logic e0;
    logic [7:0] ed;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      req0 = (i < 4); req1 = (i < 4);
      we0 = 1'b0; we1 = 1'b0;
      addr0 = 9'h011; addr1 = 9'h012;
      @(negedge clk);
      if (i < 4) begin
        e0 = ((i % 2) == 0);
        n_checks++;
        if ({gnt0, gnt1} !== {e0, ~e0}) begin
          n_fail++; $display("FAIL tie_gnt[%0d]: got %b expected %b", i, {gnt0, gnt1}, {e0, ~e0});
        end
      end
      if (i >= 2) begin
        e0 = (((i - 2) % 2) == 0);
        ed = e0 ? 8'h11 : 8'h22;
        n_checks++;
        if ({rvalid0, rvalid1} !== {e0, ~e0}) begin
          n_fail++;
          $display("FAIL tie_rvalid[%0d]: got %b expected %b", i, {rvalid0, rvalid1}, {e0, ~e0});
        end
        n_checks++;
        if (rdata !== ed) begin
          n_fail++; $display("FAIL tie_rdata[%0d]: got %h expected %h", i, rdata, ed);
        end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_locked_store();
    logic [7:0] wd [4];
    logic [8:0] a;
    wd[0] = 8'h12; wd[1] = 8'h34; wd[2] = 8'h56; wd[3] = 8'h78;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        req0 = 1'b1; we0 = 1'b1; addr0 = 9'h100 + 9'(k); wdata0 = wd[k]; lock0 = (k < 3);
      end else begin
        req0 = 1'b0; we0 = 1'b0; lock0 = 1'b0;
      end
      req1 = 1'b1; we1 = 1'b0; addr1 = 9'h005;
      @(negedge clk);
      n_checks++;
      if (k < 4) begin
        if ({gnt0, gnt1} !== 2'b10) begin
          n_fail++; $display("FAIL lock_gnt[%0d]: got %b expected 10", k, {gnt0, gnt1});
        end
      end else begin
        if ({gnt0, gnt1} !== 2'b01) begin
          n_fail++; $display("FAIL lock_gnt1_after: got %b expected 01", {gnt0, gnt1});
        end
      end
      if (k >= 1) begin
        a = 9'h100 + 9'(k - 1);
        n_checks++;
        if ({ram_we, ram_addr, ram_wdata} !== {1'b1, a, wd[k-1]}) begin
          n_fail++;
          $display("FAIL lock_ram_port[%0d]: got we=%b a=%h d=%h expected we=1 a=%h d=%h",
                   k, ram_we, ram_addr, ram_wdata, a, wd[k-1]);
        end
      end
      step();
    end
    idle_inputs();
    step();
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      a = 9'h100 + 9'(k);
      n_checks++;
      if (mem[a] !== wd[k]) begin
        n_fail++; $display("FAIL lock_ram_byte[%0d]: got %h expected %h", k, mem[a], wd[k]);
      end
    end
  endtask

  task automatic test_lock_limit();
    req1 = 1'b1; lock1 = 1'b1; we1 = 1'b0; addr1 = 9'h005;
    req0 = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({gnt0, gnt1} !== 2'b01) begin
      n_fail++; $display("FAIL limit_entry: got %b expected 01", {gnt0, gnt1});
    end
    step();
    for (int c = 1; c < 4; c++) begin
      req1 = 1'b0; lock1 = 1'b1;
      req0 = 1'b1; we0 = 1'b0; addr0 = 9'h010;
      @(negedge clk);
      n_checks++;
      if ({gnt0, gnt1} !== 2'b00) begin
        n_fail++; $display("FAIL limit_held[%0d]: got %b expected 00", c, {gnt0, gnt1});
      end
      step();
    end
    req1 = 1'b1; lock1 = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_fail++; $display("FAIL limit_release: got %b expected 10", {gnt0, gnt1});
    end
    step();
    req0 = 1'b0; lock1 = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({gnt0, gnt1} !== 2'b01) begin
      n_fail++; $display("FAIL limit_after: got %b expected 01", {gnt0, gnt1});
    end
    step();
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_reset_mid_read();
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'h010;
    @(negedge clk);
    n_checks++;
    if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL midrst_gnt: got %b expected 1", gnt0); end
    step();
    req0 = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1; addr0 = 9'h011; addr1 = 9'h012;
    @(negedge clk);
    n_checks++;
    if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL midrst_rvalid: got %b expected 0", rvalid0); end
    n_checks++;
    if ({ram_we, ram_addr} !== {1'b0, 9'h000}) begin
      n_fail++; $display("FAIL midrst_ram: got we=%b a=%h expected we=0 a=000", ram_we, ram_addr);
    end
    n_checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_fail++; $display("FAIL midrst_tie: got %b expected 10", {gnt0, gnt1});
    end
    step();
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_wr_rd_pipeline();
    req0 = 1'b1; we0 = 1'b1; addr0 = 9'h020; wdata0 = 8'h3C;
    @(negedge clk);
    n_checks++;
    if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %b expected 1", gnt0); end
    step();
    we0 = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({gnt0, ram_we} !== 2'b11) begin
      n_fail++; $display("FAIL rd_gnt_we: got %b expected 11", {gnt0, ram_we});
    end
    step();
    req0 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid: got %b expected 0", rvalid0); end
    step();
    @(negedge clk);
    n_checks++;
    if (rvalid0 !== 1'b1) begin n_fail++; $display("FAIL raw_rvalid: got %b expected 1", rvalid0); end
    n_checks++;
    if (rdata !== 8'h3C) begin n_fail++; $display("FAIL raw_rdata: got %h expected 3c", rdata); end
    step();
    @(negedge clk);
    n_checks++;
    if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL raw_rvalid_once: got %b expected 0", rvalid0); end
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pl_en    = 1'b0;
    pl_addr  = 9'h000;
    pl_data  = 8'h00;
    reset    = 1'b1;
    idle_inputs();
    step();
    test_reset();
    test_single_read();
    test_tie_rr();
    test_locked_store();
    test_lock_limit();
    test_reset_mid_read();
    test_wr_rd_pipeline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
